csr_access_arbiter: RTL



---
 rtl/csr_pkg.sv | 20 ++
 rtl/csr_access_arbiter_if.sv | 27 ++
 rtl/csr_access_arbiter_rr_arb2.sv | 33 +++
 rtl/csr_access_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access arbiter: register-map geometry,
// arbiter FSM states and requester port indices.
package csr_pkg;

  localparam int ADDR_WIDTH     = 7;
  localparam int DATA_WIDTH     = 8;
  localparam int NUM_CONFIG_REG = 10;
  localparam int NUM_STATUS_REG = 4;
  localparam int NUM_REGS       = NUM_CONFIG_REG + NUM_STATUS_REG;

  localparam int PORT_SPI = 0;
  localparam int PORT_SEQ = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage : csr_pkg

// File: rtl/csr_access_arbiter_if.sv
// Requester-side bus of the CSR access arbiter: two packed request ports plus
// the shared response. Signal suffixes are relative to the arbiter.
interface csr_access_arbiter_if #(
  parameter int ADDR_WIDTH = csr_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = csr_pkg::DATA_WIDTH
);

  logic [1:0]            req_valid_i;
  logic [1:0]            req_we_i;
  logic [2*ADDR_WIDTH-1:0] req_addr_i;
  logic [2*DATA_WIDTH-1:0] req_wdata_i;
  logic [1:0]            req_ready_o;
  logic [1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface : csr_access_arbiter_if

// File: rtl/csr_access_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the request vector,
// registered priority pointer that moves past the winner when en_i is high.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;  // 0: port 0 wins a tie, 1: port 1 wins a tie

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (en_i && (gnt_o != 2'b00)) begin
      ptr_q <= gnt_o[0];
    end
  end

endmodule : rr_arb2

// File: rtl/csr_access_arbiter.sv
// Shares one register-map port between two requesters, holding each access for
// ACCESS_CYCLES cycles. Define CSR_ARB_RANGE_CHECK_EN to reject addr >= NUM_REGS.
module csr_access_arbiter
  import csr_pkg::*;
#(
  parameter int ADDR_WIDTH    = csr_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = csr_pkg::DATA_WIDTH,
  parameter int NUM_REGS      = csr_pkg::NUM_REGS,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  csr_access_arbiter_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] map_addr_o,
  output logic [DATA_WIDTH-1:0] map_write_data_o,
  output logic                  map_write_en_o,
  output logic                  map_read_en_o,
  input  logic [DATA_WIDTH-1:0] map_read_data_i
);

`ifdef CSR_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            owner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_en_q;
  logic                  rd_en_q;
  logic [1:0]            rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic [1:0]            gnt;
  logic                  sel;
  logic                  grant_fire;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  range_err;

  assign grant_fire = (state_q == IDLE) && (bus.req_valid_i != 2'b00) && !rst_i;
  assign sel        = gnt[PORT_SEQ];
  assign sel_we     = bus.req_we_i[sel];
  assign sel_addr   = bus.req_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata  = bus.req_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign range_err  = RANGE_CHECK && (sel_addr >= ADDR_WIDTH'(NUM_REGS));

  rr_arb2 u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (bus.req_valid_i),
    .en_i  (grant_fire),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_fire) begin
            owner_q <= gnt;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            if (range_err) begin
              // Rejected access: answer immediately, map never sees a strobe.
              state_q     <= RESP;
              rsp_valid_q <= gnt;
              rsp_rdata_q <= '1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
              cnt_q   <= CNT_W'(ACCESS_CYCLES - 1);
              wr_en_q <= sel_we;
              rd_en_q <= !sel_we;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= owner_q;
            rsp_rdata_q <= we_q ? '0 : map_read_data_i;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The map's two-stage sync needs at least three held cycles per access.
  always_ff @(posedge clk_i) begin
    assert (ACCESS_CYCLES >= 3)
      else $error("csr_access_arbiter: ACCESS_CYCLES=%0d is below 3", ACCESS_CYCLES);
  end

  assign bus.req_ready_o = grant_fire ? gnt : 2'b00;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;

  assign map_addr_o       = addr_q;
  assign map_write_data_o = wdata_q;
  assign map_write_en_o   = wr_en_q;
  assign map_read_en_o    = rd_en_q;

endmodule : csr_access_arbiter
